// File: rtl/rtl_gm_lockstep_checker.sv
// Lockstep checker: steps a golden round model NR times and compares each round against an implementation tap.
// Latency: about 3 cycles per round with a zero-delay golden model (longer if LAT stalls), plus FIN and a registered done.
// Backpressure: start is taken only in IDLE and ignored while busy; gm_done is waited on for at most TO cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, in_state, in_key   launch request and stimulus, captured on an accepted start
//   busy                      check in progress
//   impl_state_o, impl_key_o  captured stimulus, held stable for the implementation
//   impl_sel                  round tap requested from the implementation (0 outside compare)
//   impl_state, impl_key      implementation tap for round impl_sel
//   gm_state_o, gm_key_o      golden-model round input (chained result of the previous round)
//   gm_step                   one-cycle request for one golden round
//   gm_done, gm_state_i/key_i golden round result, first high cycle of gm_done taken
//   done                      one-cycle end-of-check pulse
//   pass, mism_*              verdict; first failing round and which fields differed
//   err_timeout               golden model did not answer within TO cycles
module rtl_gm_lockstep_checker #(
  parameter int DW  = 128,
  parameter int KW  = 128,
  parameter int NR  = 10,
  parameter int LAT = 1,
  parameter int TO  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in_state,
  input  logic [KW-1:0] in_key,
  output logic          busy,
  output logic [DW-1:0] impl_state_o,
  output logic [KW-1:0] impl_key_o,
  output logic [3:0]    impl_sel,
  input  logic [DW-1:0] impl_state,
  input  logic [KW-1:0] impl_key,
  output logic [DW-1:0] gm_state_o,
  output logic [KW-1:0] gm_key_o,
  output logic          gm_step,
  input  logic          gm_done,
  input  logic [DW-1:0] gm_state_i,
  input  logic [KW-1:0] gm_key_i,
  output logic          done,
  output logic          pass,
  output logic [3:0]    mism_round,
  output logic          mism_state,
  output logic          mism_key,
  output logic          err_timeout
);

  // The final round waits for settle >= NR*LAT+1, so the counter must be able
  // to reach that value before it saturates.
  localparam int SAT = NR * LAT + 1;
  localparam int SW  = $clog2(SAT + 1);
  localparam int TW  = $clog2(TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_CMP,
    S_FIN
  } state_t;

  state_t        st, st_nxt;
  logic [DW-1:0] hold_state, chain_state, res_state;
  logic [KW-1:0] hold_key, chain_key, res_key;
  logic [3:0]    r;
  logic [SW-1:0] settle;
  logic [TW-1:0] tcnt;
  logic          settle_ok;
  logic          diff_state, diff_key;
  logic          to_hit;
  logic [31:0]   settle_thr;

  assign busy         = (st != S_IDLE);
  assign impl_state_o = hold_state;
  assign impl_key_o   = hold_key;
  assign gm_state_o   = chain_state;
  assign gm_key_o     = chain_key;

  // Round r's tap is trusted only once the held inputs have had r*LAT cycles
  // to propagate, plus one cycle of margin.
  assign settle_thr = 32'(r) * LAT + 32'd1;
  assign settle_ok  = (32'(settle) >= settle_thr);
  assign diff_state = (impl_state != res_state);
  assign diff_key   = (impl_key != res_key);
  assign to_hit     = (tcnt == TW'(TO - 1));

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    gm_step  = 1'b0;
    impl_sel = 4'd0;
    case (st)
      S_IDLE: if (start) st_nxt = S_STEP;
      S_STEP: begin
        gm_step = 1'b1;
        st_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (gm_done)     st_nxt = S_CMP;
        else if (to_hit) st_nxt = S_FIN;
      end
      S_CMP: begin
        impl_sel = r;
        if (settle_ok) st_nxt = (r == 4'(NR)) ? S_FIN : S_STEP;
      end
      S_FIN:   st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_state  <= '0;
      hold_key    <= '0;
      chain_state <= '0;
      chain_key   <= '0;
      res_state   <= '0;
      res_key     <= '0;
      r           <= 4'd0;
      settle      <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      mism_round  <= 4'd0;
      mism_state  <= 1'b0;
      mism_key    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= (st == S_FIN);

      if (st == S_IDLE && start) begin
        settle <= '0;
      end else if (st != S_IDLE && settle != SW'(SAT)) begin
        settle <= settle + 1'b1;
      end

      case (st)
        S_IDLE: begin
          if (start) begin
            hold_state  <= in_state;
            hold_key    <= in_key;
            chain_state <= in_state;
            chain_key   <= in_key;
            pass        <= 1'b0;
            mism_round  <= 4'd0;
            mism_state  <= 1'b0;
            mism_key    <= 1'b0;
            err_timeout <= 1'b0;
            r           <= 4'd1;
          end
        end
        S_STEP: tcnt <= '0;
        S_WAIT: begin
          if (gm_done) begin
            res_state <= gm_state_i;
            res_key   <= gm_key_i;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            mism_round  <= r;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_CMP: begin
          if (settle_ok) begin
            if ((diff_state || diff_key) && mism_round == 4'd0) begin
              mism_round <= r;
              mism_state <= diff_state;
              mism_key   <= diff_key;
            end
            // The golden chain is authoritative: later rounds start from the
            // golden result even when the implementation disagreed.
            chain_state <= res_state;
            chain_key   <= res_key;
            if (r != 4'(NR)) r <= r + 4'd1;
          end
        end
        S_FIN:   pass <= (mism_round == 4'd0) && !err_timeout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl_gm_lockstep_checker.sv
`timescale 1ns/1ps
// Bench for rtl_gm_lockstep_checker: instance 0 with LAT=1, instance 1 with LAT=4.
// Stubs: golden round is state+1, key^1; implementation tap k is in_state+k, in_key^(k&1),
// with per-round fault masks and garbage returned before the tap has settled.
module tb_rtl_gm_lockstep_checker;
  localparam int DW = 128;
  localparam int KW = 128;
  localparam int NR = 10;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] in_state;
  logic [KW-1:0] in_key;

  logic          start        [2];
  logic          busy         [2];
  logic [DW-1:0] impl_state_o [2];
  logic [KW-1:0] impl_key_o   [2];
  logic [3:0]    impl_sel     [2];
  logic [DW-1:0] impl_state   [2];
  logic [KW-1:0] impl_key     [2];
  logic [DW-1:0] gm_state_o   [2];
  logic [KW-1:0] gm_key_o     [2];
  logic          gm_step      [2];
  logic          gm_done      [2];
  logic [DW-1:0] gm_state_i   [2];
  logic [KW-1:0] gm_key_i     [2];
  logic          done         [2];
  logic          pass         [2];
  logic [3:0]    mism_round   [2];
  logic          mism_state   [2];
  logic          mism_key     [2];
  logic          err_timeout  [2];

  logic [15:0]   st_mask    [2];
  logic [15:0]   key_mask   [2];
  logic [3:0]    hang_round [2];
  logic          force_done [2];
  logic [DW-1:0] base       [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 4;

    rtl_gm_lockstep_checker #(.DW(DW), .KW(KW), .NR(NR), .LAT(L), .TO(TO)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .in_state(in_state), .in_key(in_key),
      .busy(busy[g]), .impl_state_o(impl_state_o[g]), .impl_key_o(impl_key_o[g]),
      .impl_sel(impl_sel[g]), .impl_state(impl_state[g]), .impl_key(impl_key[g]),
      .gm_state_o(gm_state_o[g]), .gm_key_o(gm_key_o[g]), .gm_step(gm_step[g]),
      .gm_done(gm_done[g]), .gm_state_i(gm_state_i[g]), .gm_key_i(gm_key_i[g]),
      .done(done[g]), .pass(pass[g]), .mism_round(mism_round[g]),
      .mism_state(mism_state[g]), .mism_key(mism_key[g]), .err_timeout(err_timeout[g])
    );

    // Cycles since the implementation inputs changed (0 in the cycle after capture).
    int el;
    always @(posedge clk) begin
      if (rst)                        el <= 0;
      else if (start[g] && !busy[g])  el <= 0;
      else                            el <= el + 1;
    end

    logic tap_ok;
    assign tap_ok = (el >= int'(impl_sel[g]) * L + 1);
    assign impl_state[g] = !tap_ok ? ~(impl_state_o[g] + DW'(impl_sel[g])) :
                           impl_state_o[g] + DW'(impl_sel[g]) +
                           (st_mask[g][impl_sel[g]] ? DW'(2) : DW'(0));
    assign impl_key[g] = impl_key_o[g] ^ KW'(impl_sel[g][0]) ^
                         (key_mask[g][impl_sel[g]] ? KW'(4) : KW'(0));

    logic          gd;
    logic [DW-1:0] gs;
    logic [KW-1:0] gk;
    always @(posedge clk) begin
      if (rst) begin
        gd <= 1'b0; gs <= '0; gk <= '0;
      end else begin
        gd <= 1'b0;
        if (force_done[g]) begin
          gd <= 1'b1; gs <= ~gm_state_o[g]; gk <= ~gm_key_o[g];
        end else if (gm_step[g] &&
                     !(hang_round[g] != 4'd0 &&
                       gm_state_o[g] == base[g] + DW'(hang_round[g] - 4'd1))) begin
          gd <= 1'b1; gs <= gm_state_o[g] + DW'(1); gk <= gm_key_o[g] ^ KW'(1);
        end
      end
    end
    assign gm_done[g]    = gd;
    assign gm_state_i[g] = gs;
    assign gm_key_i[g]   = gk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         g;
    logic       pass;
    logic [3:0] mr;
    logic       ms;
    logic       mk;
    logic       to;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   done_cnt [2] = '{0, 0};

  // Cycle (relative to the start cycle) of done: round r's compare happens at the
  // later of 3 cycles after the previous one and the cycle where settle reaches r*L+1
  // (settle is cycle-1); done is two cycles after the last compare. A hang in round h
  // gives gm_step one cycle after round h-1, TO wait cycles, FIN, then done.
  function automatic int lat_model(input int L, input int h);
    int c = 0;
    for (int r = 1; r <= NR; r++) begin
      if (h == r) return c + TO + 3;
      c = (c + 3 > r * L + 2) ? c + 3 : r * L + 2;
    end
    return c + 2;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (done[g]) begin
        done_cnt[g]++;
        if (sb.size() == 0) begin
          check_val("unexpected_done", 128'(g + 1), 128'(0));
        end else begin
          e_mon = sb.pop_front();
          check_val("done_inst",    128'(g), 128'(e_mon.g));
          check_val("pass",         pass[g], e_mon.pass);
          check_val("mism_round",   mism_round[g], e_mon.mr);
          check_val("mism_state",   mism_state[g], e_mon.ms);
          check_val("mism_key",     mism_key[g], e_mon.mk);
          check_val("err_timeout",  err_timeout[g], e_mon.to);
          check_val("latency",      128'(cyc - e_mon.t0), 128'(e_mon.lat));
          check_val("busy_at_done", busy[g], 1'b0);
        end
      end
    end
  end

  task automatic run(input int g, input logic [DW-1:0] s, input logic [KW-1:0] k,
                     input logic ep, input logic [3:0] emr, input logic ems,
                     input logic emk, input logic eto, input int lat);
    exp_t e;
    int   n0;
    n0 = done_cnt[g];
    base[g]  = s;
    in_state = s;
    in_key   = k;
    @(negedge clk);
    e.g = g; e.pass = ep; e.mr = emr; e.ms = ems; e.mk = emk; e.to = eto;
    e.t0 = cyc; e.lat = lat;
    sb.push_back(e);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    for (int i = 0; i < 300 && done_cnt[g] == n0; i++) @(negedge clk);
    if (done_cnt[g] == n0) check_val("done_timeout", 128'(0), 128'(1));
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] s;
    int            n0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; st_mask[g] = '0; key_mask[g] = '0;
      hang_round[g] = 4'd0; force_done[g] = 1'b0; base[g] = '0;
    end
    in_state = '0;
    in_key   = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy",        busy[0], 1'b0);
    check_val("rst_done",        done[0], 1'b0);
    check_val("rst_pass",        pass[0], 1'b0);
    check_val("rst_mism_round",  mism_round[0], 4'd0);
    check_val("rst_err_timeout", err_timeout[0], 1'b0);
    check_val("rst_impl_sel",    impl_sel[0], 4'd0);
    check_val("rst_impl_state",  impl_state_o[0], '0);
    check_val("rst_gm_step",     gm_step[0], 1'b0);
    check_val("rst_busy1",       busy[1], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Matching stubs, zero stimulus.
    run(0, '0, '0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, lat_model(1, 0));

    // State fault at round 3; a later state+key fault at round 6 must not overwrite it.
    st_mask[0] = 16'h0048; key_mask[0] = 16'h0040;
    run(0, rnd128(), rnd128(), 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, lat_model(1, 0));

    // Key-only fault at the first round.
    st_mask[0] = '0; key_mask[0] = 16'h0002;
    run(0, rnd128(), rnd128(), 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, lat_model(1, 0));

    // Both fields wrong at the last round.
    st_mask[0] = 16'h0400; key_mask[0] = 16'h0400;
    run(0, rnd128(), rnd128(), 1'b0, 4'd10, 1'b1, 1'b1, 1'b0, lat_model(1, 0));
    st_mask[0] = '0; key_mask[0] = '0;

    // Golden model hangs in round 2.
    hang_round[0] = 4'd2;
    run(0, '0, '0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, lat_model(1, 2));
    hang_round[0] = 4'd0;

    // Deep pipeline instance: clean run, then last-round state fault.
    run(1, rnd128(), rnd128(), 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, lat_model(4, 0));
    st_mask[1] = 16'h0400;
    run(1, rnd128(), rnd128(), 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, lat_model(4, 0));
    st_mask[1] = '0;

    // Reset in round 5 aborts the run without a done pulse.
    in_state = rnd128(); in_key = rnd128(); base[0] = in_state;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    check_val("midrun_busy", busy[0], 1'b1);
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    check_val("abort_busy",       busy[0], 1'b0);
    check_val("abort_done",       done[0], 1'b0);
    check_val("abort_impl_state", impl_state_o[0], '0);
    check_val("abort_mism_round", mism_round[0], 4'd0);
    @(negedge clk);
    check_val("rst_start_busy", busy[0], 1'b0);
    run(0, {16{8'hAA}}, {16{8'h55}}, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, lat_model(1, 0));
    check_val("new_impl_state", impl_state_o[0], {16{8'hAA}});
    check_val("new_impl_key",   impl_key_o[0], {16{8'h55}});

    // Start pulses while busy must be ignored; one done per accepted start.
    s = rnd128();
    fork
      run(0, s, rnd128(), 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, lat_model(1, 0));
      begin
        repeat (6) @(negedge clk);
        in_state = ~s; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        in_state = s ^ 128'h1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    check_val("held_impl_state", impl_state_o[0], s);
    n0 = done_cnt[0];
    repeat (40) @(negedge clk);
    check_val("single_done", 128'(done_cnt[0]), 128'(n0));

    // Spurious gm_done while idle.
    force_done[0] = 1'b1;
    @(negedge clk);
    force_done[0] = 1'b0;
    repeat (5) @(negedge clk);
    check_val("idle_gm_done_busy", busy[0], 1'b0);
    check_val("idle_gm_done_cnt",  128'(done_cnt[0]), 128'(n0));
    check_val("idle_pass_held",    pass[0], 1'b1);

    check_val("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
